// File: rtl/qif_pkg.sv
// Shared types and helpers for the time-multiplexed QIF neuron array.
// Holds the default widths, the sweep FSM state type and the saturation helper.
package qif_pkg;

    localparam int W_DEF  = 8;
    localparam int WF_DEF = 2 * W_DEF + 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    // Clamp a wide signed value into the range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat_wide(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/qif_neuron_array_if.sv
// Control and event bus of the QIF neuron array; the array is the slave side.
// spike_valid and sweep_done are single-cycle pulses with no backpressure: the
// consumer must sample spike_id in the same cycle spike_valid is high.
interface qif_neuron_array_if #(
    parameter int N_CH = 4,
    parameter int W    = qif_pkg::W_DEF
);
    localparam int CW = $clog2(N_CH);

    logic                  ena;
    logic [N_CH*W-1:0]     i_syn;
    logic [CW-1:0]         sel;
    logic signed [W-1:0]   v_sel;
    logic                  spike_valid;
    logic [CW-1:0]         spike_id;
    logic                  sweep_done;
    logic                  overrun;
    qif_pkg::state_t       dbg_state;
    logic [CW-1:0]         dbg_idx;

    modport master (
        output ena, i_syn, sel,
        input  v_sel, spike_valid, spike_id, sweep_done, overrun, dbg_state, dbg_idx
    );

    modport slave (
        input  ena, i_syn, sel,
        output v_sel, spike_valid, spike_id, sweep_done, overrun, dbg_state, dbg_idx
    );

endinterface

// File: rtl/qif_update.sv
// Combinational QIF step for one channel: quadratic integrate, saturate,
// threshold, reset and refractory countdown.
module qif_update
    import qif_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int SQ_SHIFT = 5,
    parameter int V_TH     = 64,
    parameter int V_RESET  = -16,
    parameter int REFRAC   = 2,
    parameter int RW       = 2
) (
    input  logic signed [W-1:0] v,
    input  logic signed [W-1:0] i_cur,
    input  logic [RW-1:0]       refr,
    output logic signed [W-1:0] vn,
    output logic [RW-1:0]       refr_n,
    output logic                spike
);

    localparam int WF = 2 * W + 1;
    localparam logic signed [W-1:0] TH       = W'(V_TH);
    localparam logic signed [W-1:0] RST_V    = W'(V_RESET);
    localparam logic [RW-1:0]       REFRAC_R = RW'(REFRAC);

    logic signed [WF-1:0] v_x;
    logic signed [WF-1:0] i_x;
    logic signed [WF-1:0] sq;
    logic signed [WF-1:0] sum;
    logic signed [W-1:0]  v_sat;

    always_comb begin
        v_x    = WF'(v);
        i_x    = WF'(i_cur);
        sq     = (v_x * v_x) >>> SQ_SHIFT;
        sum    = v_x + sq + i_x;
        // Saturate first so a wrapped sum can never sneak under the threshold.
        v_sat  = W'(sat_wide(64'(sum), W));
        vn     = v_sat;
        refr_n = '0;
        spike  = 1'b0;
        if (refr != '0) begin
            vn     = RST_V;
            refr_n = refr - RW'(1);
        end else if (v_sat >= TH) begin
            vn     = RST_V;
            refr_n = REFRAC_R;
            spike  = 1'b1;
        end
    end

endmodule

// File: rtl/qif_neuron_array.sv
// N_CH QIF neurons sharing one update datapath; a prescaled tick launches a
// sweep that visits one channel per cycle and emits registered spike events.
module qif_neuron_array
    import qif_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int W        = W_DEF,
    parameter int SQ_SHIFT = 5,
    parameter int V_TH     = 64,
    parameter int V_RESET  = -16,
    parameter int REFRAC   = 2,
    parameter int TICK_DIV = 10_000_000
) (
    input logic               clk,
    input logic               rst_n,
    qif_neuron_array_if.slave bus
);

    localparam int CW = $clog2(N_CH);
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] IDX_LAST = CW'(N_CH - 1);

    state_t              state;
    logic [CW-1:0]       idx;
    logic [PW-1:0]       presc;
    logic                tick;

    logic signed [W-1:0] v_mem    [N_CH];
    logic [RW-1:0]       refr_mem [N_CH];

    logic signed [W-1:0] v_cur;
    logic signed [W-1:0] i_cur;
    logic signed [W-1:0] v_rd;
    logic signed [W-1:0] vn;
    logic [RW-1:0]       refr_cur;
    logic [RW-1:0]       refr_n;
    logic                spike;

    assign tick          = bus.ena && (presc == PRE_LAST);
    assign bus.dbg_state = state;
    assign bus.dbg_idx   = idx;

    // Channel muxes; an out-of-range sel falls back to channel 0.
    always_comb begin
        v_cur    = v_mem[0];
        refr_cur = refr_mem[0];
        i_cur    = bus.i_syn[W-1:0];
        v_rd     = v_mem[0];
        for (int k = 0; k < N_CH; k++) begin
            if (idx == CW'(k)) begin
                v_cur    = v_mem[k];
                refr_cur = refr_mem[k];
                i_cur    = bus.i_syn[k*W +: W];
            end
            if (bus.sel == CW'(k)) begin
                v_rd = v_mem[k];
            end
        end
    end

    qif_update #(
        .W        (W),
        .SQ_SHIFT (SQ_SHIFT),
        .V_TH     (V_TH),
        .V_RESET  (V_RESET),
        .REFRAC   (REFRAC),
        .RW       (RW)
    ) u_update (
        .v      (v_cur),
        .i_cur  (i_cur),
        .refr   (refr_cur),
        .vn     (vn),
        .refr_n (refr_n),
        .spike  (spike)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            idx             <= '0;
            presc           <= '0;
            bus.v_sel       <= '0;
            bus.spike_valid <= 1'b0;
            bus.spike_id    <= '0;
            bus.sweep_done  <= 1'b0;
            bus.overrun     <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                v_mem[k]    <= '0;
                refr_mem[k] <= '0;
            end
        end else begin
            bus.spike_valid <= 1'b0;
            bus.sweep_done  <= 1'b0;
            if (bus.ena) begin
                presc     <= tick ? '0 : presc + PW'(1);
                bus.v_sel <= v_rd;
                case (state)
                    ST_IDLE: begin
                        if (tick) begin
                            state <= ST_UPDATE;
                            idx   <= '0;
                        end
                    end
                    ST_UPDATE: begin
                        for (int k = 0; k < N_CH; k++) begin
                            if (idx == CW'(k)) begin
                                v_mem[k]    <= vn;
                                refr_mem[k] <= refr_n;
                            end
                        end
                        bus.spike_valid <= spike;
                        bus.spike_id    <= idx;
                        // A tick landing mid-sweep is dropped but remembered.
                        if (tick) begin
                            bus.overrun <= 1'b1;
                        end
                        if (idx == IDX_LAST) begin
                            state          <= ST_IDLE;
                            idx            <= '0;
                            bus.sweep_done <= 1'b1;
                        end else begin
                            idx <= idx + CW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
